addsub_muldiv_ctrl: RTL



---
 rtl/addsub_muldiv_pkg.sv | 20 ++
 rtl/addsub_muldiv_ctrl_if.sv | 27 ++
 rtl/addsub_muldiv_ctrl_addsub.sv | 18 +
 rtl/addsub_muldiv_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/addsub_muldiv_pkg.sv
// Shared types and constants for the add/sub-based multiply/divide sequencer.
package addsub_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int N_ITER = 4;

    // Value of the 2-bit iteration counter on the final RUN cycle.
    function automatic logic [1:0] last_iter();
        return 2'(N_ITER - 1);
    endfunction

endpackage

// File: rtl/addsub_muldiv_ctrl_if.sv
// Request/response bundle between a request source and the multiply/divide sequencer.
interface addsub_muldiv_ctrl_if;

    // start/op/x/y are sampled together on a rising edge while the sequencer is idle
    // (busy=0); requests seen while busy are dropped. done is a one-cycle pulse, and
    // dz/result_hi/result_lo are valid from that pulse until the next accepted start.
    logic       start;
    logic       op;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       dz;
    logic [3:0] result_hi;
    logic [3:0] result_lo;

    modport master (
        output start, op, x, y,
        input  busy, done, dz, result_hi, result_lo
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, dz, result_hi, result_lo
    );

endinterface

// File: rtl/addsub_muldiv_ctrl_addsub.sv
// Existing 4-bit adder/subtractor: c0=0 adds, c0=1 subtracts (a + ~b + 1, c4=1 means no borrow).
module FourBitAddrSub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       v
);

    logic [3:0] b_eff;

    assign b_eff   = c0 ? ~b : b;
    assign {c4, s} = {1'b0, a} + {1'b0, b_eff} + {4'd0, c0};
    // Signed overflow: operands of equal sign give a result of the other sign.
    assign v       = (a[3] == b_eff[3]) && (s[3] != a[3]);

endmodule

// File: rtl/addsub_muldiv_ctrl.sv
// Shift-add multiply / restoring divide sequencer around one FourBitAddrSub.
// Divide support is compiled in only when ADDSUB_MULDIV_DIV_EN is defined.
module addsub_muldiv_ctrl
    import addsub_muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    addsub_muldiv_ctrl_if.slave  bus,
    output state_t               state_dbg
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [3:0] hi_q;     // acc (multiply) or partial remainder r (divide)
    logic [3:0] lo_q;     // q: multiplier bits out / quotient bits in
    logic [3:0] opnd_q;   // m (multiply) or d (divide)
    logic [3:0] res_hi;
    logic [3:0] res_lo;
    logic       dz_q;

    logic       accept;
    logic       step;
    logic       finish;
    logic       req_div;
    logic       req_dz;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_c0;
    logic [3:0] add_s;
    logic       add_c4;
    logic       adder_v_unused;

    logic [4:0] mul_sum;
    logic [3:0] mul_hi_nxt;
    logic [3:0] mul_lo_nxt;
    logic [3:0] iter_hi;
    logic [3:0] iter_lo;

    // ---------------- multiply step ----------------
    assign mul_sum    = lo_q[0] ? {add_c4, add_s} : {1'b0, hi_q};
    assign mul_hi_nxt = mul_sum[4:1];
    assign mul_lo_nxt = {mul_sum[0], lo_q[3:1]};

`ifdef ADDSUB_MULDIV_DIV_EN
    logic       div_q;
    logic [3:0] r_shift;
    logic       div_take;
    logic [3:0] div_hi_nxt;
    logic [3:0] div_lo_nxt;

    assign req_div    = (bus.op == OP_DIV);
    assign req_dz     = req_div && (bus.y == 4'd0);

    // The bit shifted out of r acts as a 5th remainder bit, so a set msb always subtracts.
    assign r_shift    = {hi_q[2:0], lo_q[3]};
    assign div_take   = hi_q[3] | add_c4;
    assign div_hi_nxt = div_take ? add_s : r_shift;
    assign div_lo_nxt = {lo_q[2:0], div_take};

    assign add_a      = div_q ? r_shift : hi_q;
    assign add_b      = opnd_q;
    assign add_c0     = div_q;
    assign iter_hi    = div_q ? div_hi_nxt : mul_hi_nxt;
    assign iter_lo    = div_q ? div_lo_nxt : mul_lo_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= 1'b0;
        end else if (accept) begin
            div_q <= req_div;
        end
    end
`else
    logic op_unused;

    assign op_unused = bus.op;
    assign req_div   = 1'b0;
    assign req_dz    = 1'b0;
    assign add_a     = hi_q;
    assign add_b     = opnd_q;
    assign add_c0    = 1'b0;
    assign iter_hi   = mul_hi_nxt;
    assign iter_lo   = mul_lo_nxt;
`endif

    FourBitAddrSub u_addsub (
        .a  (add_a),
        .b  (add_b),
        .c0 (add_c0),
        .s  (add_s),
        .c4 (add_c4),
        .v  (adder_v_unused)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = req_dz ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == last_iter()) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 2'd0;
            hi_q   <= 4'd0;
            lo_q   <= 4'd0;
            opnd_q <= 4'd0;
            res_hi <= 4'd0;
            res_lo <= 4'd0;
            dz_q   <= 1'b0;
        end else if (accept) begin
            cnt    <= 2'd0;
            hi_q   <= 4'd0;
            lo_q   <= req_div ? bus.x : bus.y;
            opnd_q <= req_div ? bus.y : bus.x;
            dz_q   <= req_dz;
            if (req_dz) begin
                res_hi <= bus.x;
                res_lo <= 4'hF;
            end
        end else if (step) begin
            cnt  <= cnt + 2'd1;
            hi_q <= iter_hi;
            lo_q <= iter_lo;
            // Results are published on the same edge that enters DONE.
            if (finish) begin
                res_hi <= iter_hi;
                res_lo <= iter_lo;
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.dz        = dz_q;
    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;
    assign state_dbg     = state;

endmodule
